// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared 12-bit address / 4-bit data memory bus (CPU core = m0, loader/debug = m1).
// Latency: req seen in IDLE -> mem_* driven next cycle -> ack MEM_LAT+1 cycles after req; locked run = 1 access per MEM_LAT+1.
// Backpressure: masters hold req and fields until their ack pulse; round-robin on BUS_ARB_RR_EN, else m0 wins ties.
module bus_arbiter #(
    parameter int MEM_LAT  = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic        m0_rw,
    input  logic [11:0] m0_addr,
    input  logic [3:0]  m0_wdata,
    output logic        m0_ack,
    output logic [3:0]  m0_rdata,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic        m1_rw,
    input  logic [11:0] m1_addr,
    input  logic [3:0]  m1_wdata,
    output logic        m1_ack,
    output logic [3:0]  m1_rdata,
    output logic [11:0] mem_addr,
    output logic        mem_rw,
    output logic [3:0]  mem_wdata,
    input  logic [3:0]  mem_rdata,
    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  lat_cnt;
    logic [3:0]  hold_cnt;
    logic [3:0]  hold_nxt;
    logic        grant;
    logic        grant_idx;
    logic        win;
    logic        own_req;
    logic        own_lock;
    logic        other_req;
    logic        forced;
    logic        lat_last;
    logic        sel_rw;
    logic [11:0] sel_addr;
    logic [3:0]  sel_wdata;

`ifdef BUS_ARB_RR_EN
    logic last_owner;

    // On a tie the master that did not own the bus last time wins.
    always_comb begin
        win = m1_req;
        if (m0_req && m1_req) begin
            win = ~last_owner;
        end
    end
`else
    always_comb begin
        win = ~m0_req;
    end
`endif

    assign own_req   = owner ? m1_req  : m0_req;
    assign own_lock  = owner ? m1_lock : m0_lock;
    assign other_req = owner ? m0_req  : m1_req;
    assign forced    = (hold_cnt == HOLD_MAX) && other_req;
    assign lat_last  = (lat_cnt == LAT_LAST);

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        grant     = 1'b0;
        grant_idx = owner;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant     = 1'b1;
                    grant_idx = win;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (own_req && own_lock && !forced) begin
                    grant     = 1'b1;
                    grant_idx = owner;
                    state_nxt = ACCESS;
                    hold_nxt  = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 4'd1;
                end else begin
                    hold_nxt = 4'd0;
                    // Hand over straight from DONE so the waiting master loses no idle cycle.
                    if (other_req) begin
                        grant     = 1'b1;
                        grant_idx = ~owner;
                        state_nxt = ACCESS;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign sel_rw    = grant_idx ? m1_rw    : m0_rw;
    assign sel_addr  = grant_idx ? m1_addr  : m0_addr;
    assign sel_wdata = grant_idx ? m1_wdata : m0_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= 2'd0;
            hold_cnt  <= 4'd0;
            owner     <= 1'b0;
            mem_addr  <= 12'd0;
            mem_rw    <= 1'b0;
            mem_wdata <= 4'd0;
            m0_rdata  <= 4'd0;
            m1_rdata  <= 4'd0;
`ifdef BUS_ARB_RR_EN
            last_owner <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            if (grant) begin
                owner     <= grant_idx;
                mem_addr  <= sel_addr;
                mem_rw    <= sel_rw;
                mem_wdata <= sel_wdata;
                lat_cnt   <= 2'd0;
`ifdef BUS_ARB_RR_EN
                last_owner <= grant_idx;
`endif
            end else if (state == ACCESS) begin
                lat_cnt <= lat_cnt + 2'd1;
                if (lat_last) begin
                    mem_rw <= 1'b0;
                    if (owner) begin
                        m1_rdata <= mem_rdata;
                    end else begin
                        m0_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    assign busy   = (state == ACCESS);
    assign m0_ack = (state == DONE) && !owner;
    assign m1_ack = (state == DONE) && owner;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: MAX_HOLD=2/MEM_LAT=1 instance with an ack scoreboard, plus a MEM_LAT=3 instance.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_lock, m0_rw, m0_ack;
    logic [11:0] m0_addr;
    logic [3:0]  m0_wdata, m0_rdata;
    logic        m1_req, m1_lock, m1_rw, m1_ack;
    logic [11:0] m1_addr;
    logic [3:0]  m1_wdata, m1_rdata;
    logic [11:0] mem_addr;
    logic        mem_rw, owner, busy;
    logic [3:0]  mem_wdata, mem_rdata;

    logic        l_req, l_rw, l_ack, l_m1_ack, l_mem_rw, l_owner, l_busy;
    logic [11:0] l_addr, l_mem_addr;
    logic [3:0]  l_wdata, l_rdata, l_m1_rdata, l_mem_wdata, l_mem_rdata;

    typedef struct {
        logic        who;
        logic [11:0] addr;
        logic        rw;
        logic [3:0]  wdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] mem_model(input logic [11:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ 4'hA;
    endfunction

    assign mem_rdata   = mem_model(mem_addr);
    assign l_mem_rdata = mem_model(l_mem_addr);

    bus_arbiter #(.MEM_LAT(1), .MAX_HOLD(2)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_rw(m0_rw), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_rw(m1_rw), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );

    bus_arbiter #(.MEM_LAT(3), .MAX_HOLD(8)) u_lat3 (
        .clk(clk), .rst(rst),
        .m0_req(l_req), .m0_lock(1'b0), .m0_rw(l_rw), .m0_addr(l_addr),
        .m0_wdata(l_wdata), .m0_ack(l_ack), .m0_rdata(l_rdata),
        .m1_req(1'b0), .m1_lock(1'b0), .m1_rw(1'b0), .m1_addr(12'h000),
        .m1_wdata(4'h0), .m1_ack(l_m1_ack), .m1_rdata(l_m1_rdata),
        .mem_addr(l_mem_addr), .mem_rw(l_mem_rw), .mem_wdata(l_mem_wdata),
        .mem_rdata(l_mem_rdata), .owner(l_owner), .busy(l_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic who, input logic [11:0] addr, input logic rw, input logic [3:0] wdata);
        exp_t e;
        e.who   = who;
        e.addr  = addr;
        e.rw    = rw;
        e.wdata = wdata;
        sb_q.push_back(e);
    endtask

    task automatic wait_ack(input logic who, input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (((who ? m1_ack : m0_ack) !== 1'b1) && cyc < budget);
        check("ack_timeout", 32'(who ? m1_ack : m0_ack), 32'd1);
    endtask

    task automatic set_req(input logic who, input logic val);
        if (who) m1_req = val;
        else     m0_req = val;
    endtask

    // Scoreboard: every ack must match the next queued access in order.
    always @(negedge clk) begin
        if (!rst) begin
            check("acks_exclusive", 32'(m0_ack & m1_ack), 32'd0);
            check("rw_only_in_access", 32'(mem_rw & ~busy), 32'd0);
            if (m0_ack || m1_ack) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_ack", 32'(sb_q.size()), 32'd1);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_who", 32'(m1_ack), 32'(mon_e.who));
                    check("sb_addr", 32'(mem_addr), 32'(mon_e.addr));
                    if (mon_e.rw)
                        check("sb_wdata", 32'(mem_wdata), 32'(mon_e.wdata));
                    else
                        check("sb_rdata", 32'(mon_e.who ? m1_rdata : m0_rdata), 32'(mem_model(mon_e.addr)));
                end
            end
        end
    end

    initial begin
        int   cyc;
        int   rw_cnt;
        logic first;

        rst = 1'b1;
        m0_req = 1'b0; m0_lock = 1'b0; m0_rw = 1'b0; m0_addr = 12'h000; m0_wdata = 4'h0;
        m1_req = 1'b0; m1_lock = 1'b0; m1_rw = 1'b0; m1_addr = 12'h000; m1_wdata = 4'h0;
        l_req = 1'b0; l_rw = 1'b0; l_addr = 12'h000; l_wdata = 4'h0;
        tick();
        tick();
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_ctrl", 32'({m0_ack, m1_ack, mem_rw, owner, busy}), 32'd0);
        check("rst_data", 32'({m0_rdata, m1_rdata, mem_wdata}), 32'd0);
        rst = 1'b0;
        tick();

        // m0 read 0x123, MEM_LAT=1
        m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 12'h123;
        push(1'b0, 12'h123, 1'b0, 4'h0);
        tick();
        check("t1_addr_c1", 32'(mem_addr), 32'h123);
        check("t1_busy_c1", 32'(busy), 32'd1);
        check("t1_rw_c1", 32'(mem_rw), 32'd0);
        check("t1_no_early_ack", 32'(m0_ack), 32'd0);
        tick();
        check("t1_ack_c2", 32'(m0_ack), 32'd1);
        check("t1_rdata", 32'(m0_rdata), 32'hA);
        check("t1_rw_c2", 32'(mem_rw), 32'd0);
        m0_req = 1'b0;
        tick();
        check("t1_ack_one_cycle", 32'(m0_ack), 32'd0);
        check("t1_rdata_held", 32'(m0_rdata), 32'hA);

        // simultaneous unlocked requests, last owner is m0
`ifdef BUS_ARB_RR_EN
        first = 1'b1;
`else
        first = 1'b0;
`endif
        m0_req = 1'b1; m0_addr = 12'h010;
        m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 12'h020;
        push(first, first ? 12'h020 : 12'h010, 1'b0, 4'h0);
        push(~first, first ? 12'h010 : 12'h020, 1'b0, 4'h0);
        wait_ack(first, 6, cyc);
        check("sim_first_lat", 32'(cyc), 32'd2);
        set_req(first, 1'b0);
        wait_ack(~first, 6, cyc);
        check("sim_second_from_done", 32'(cyc), 32'd2);
        set_req(~first, 1'b0);
        tick();

        // m1 write 0xFFF <- 0x5
        m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 12'hFFF; m1_wdata = 4'h5;
        push(1'b1, 12'hFFF, 1'b1, 4'h5);
        tick();
        check("t2_rw_c1", 32'(mem_rw), 32'd1);
        check("t2_addr", 32'(mem_addr), 32'hFFF);
        check("t2_wdata", 32'(mem_wdata), 32'h5);
        check("t2_owner", 32'(owner), 32'd1);
        tick();
        check("t2_ack", 32'(m1_ack), 32'd1);
        check("t2_rw_done", 32'(mem_rw), 32'd0);
        check("t2_m0_ack_low", 32'(m0_ack), 32'd0);
        m1_req = 1'b0; m1_rw = 1'b0;
        tick();

        // m0 locked 3-nibble fetch while m1 waits
        m0_req = 1'b1; m0_lock = 1'b1; m0_rw = 1'b0; m0_addr = 12'h000;
        m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 12'h0F0;
        push(1'b0, 12'h000, 1'b0, 4'h0);
        push(1'b0, 12'h001, 1'b0, 4'h0);
        push(1'b0, 12'h002, 1'b0, 4'h0);
        push(1'b1, 12'h0F0, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            wait_ack(1'b0, 6, cyc);
            check("lock_fetch_lat", 32'(cyc), 32'd2);
            if (i < 2) begin
                m0_addr = 12'(i + 1);
            end else begin
                m0_req = 1'b0; m0_lock = 1'b0;
            end
        end
        wait_ack(1'b1, 6, cyc);
        check("lock_release_lat", 32'(cyc), 32'd2);
        m1_req = 1'b0;
        tick();

        // m0 holds lock forever: forced release after 1 + MAX_HOLD accesses
        m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 12'h200;
        m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 12'h300; m1_wdata = 4'h9;
        push(1'b0, 12'h200, 1'b0, 4'h0);
        push(1'b0, 12'h201, 1'b0, 4'h0);
        push(1'b0, 12'h202, 1'b0, 4'h0);
        push(1'b1, 12'h300, 1'b1, 4'h9);
        push(1'b0, 12'h203, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            wait_ack(1'b0, 6, cyc);
            check("hold_m0_lat", 32'(cyc), 32'd2);
            m0_addr = 12'h200 + 12'(i + 1);
        end
        wait_ack(1'b1, 6, cyc);
        check("hold_forced_lat", 32'(cyc), 32'd2);
        m1_req = 1'b0; m1_rw = 1'b0;
        wait_ack(1'b0, 6, cyc);
        check("hold_m0_reserved_lat", 32'(cyc), 32'd2);
        m0_req = 1'b0; m0_lock = 1'b0;
        tick();

        // reset in the middle of an m1 write
        m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 12'h456; m1_wdata = 4'h3;
        tick();
        check("rst_pre_rw", 32'(mem_rw), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_mid_ctrl", 32'({m0_ack, m1_ack, mem_rw, owner, busy}), 32'd0);
        check("rst_mid_addr", 32'(mem_addr), 32'd0);
        check("rst_mid_data", 32'({m0_rdata, m1_rdata, mem_wdata}), 32'd0);
        rst = 1'b0; m1_req = 1'b0; m1_rw = 1'b0;
        tick();
        check("rst_post_no_ack", 32'({m0_ack, m1_ack, busy}), 32'd0);
        m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 12'h7E5;
        push(1'b0, 12'h7E5, 1'b0, 4'h0);
        wait_ack(1'b0, 6, cyc);
        check("rst_fresh_lat", 32'(cyc), 32'd2);
        m0_req = 1'b0;
        tick();

        // MEM_LAT=3 instance: write then read
        l_req = 1'b1; l_rw = 1'b1; l_addr = 12'hABC; l_wdata = 4'hC;
        cyc = 0; rw_cnt = 0;
        do begin
            tick();
            cyc++;
            if (l_mem_rw) rw_cnt++;
        end while (l_ack !== 1'b1 && cyc < 10);
        check("lat3_wr_ack_cycle", 32'(cyc), 32'd4);
        check("lat3_rw_cycles", 32'(rw_cnt), 32'd3);
        check("lat3_wdata", 32'(l_mem_wdata), 32'hC);
        check("lat3_m1_idle", 32'({l_m1_ack, l_owner, l_busy}), 32'd0);
        l_req = 1'b0; l_rw = 1'b0;
        tick();
        l_req = 1'b1; l_addr = 12'h0AB;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (l_ack !== 1'b1 && cyc < 10);
        check("lat3_rd_ack_cycle", 32'(cyc), 32'd4);
        check("lat3_rdata", 32'(l_rdata), 32'(mem_model(12'h0AB)));
        check("lat3_m1_rdata", 32'(l_m1_rdata), 32'd0);
        l_req = 1'b0;
        tick();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single 12-bit address / 4-bit data memory bus between two masters.
- Master 0 is the CPU core. Master 1 is the program loader / debug port.
- Per-master req/ack handshake, registered bus drive, and a lock so multi-nibble sequences (instruction fetch, 12-bit pointer load) are not interleaved.
- A hold limit caps how long one master may keep the bus while the other is waiting.
- Sits between the masters and the memory/bus interface.

Parameters:
- MEM_LAT, 1: cycles from mem_addr valid to mem_rdata valid. Range 1..4.
- MAX_HOLD, 8: maximum back-to-back locked accesses by one owner while the other master is requesting. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- m0_req  in  1  master 0 access request; held until m0_ack
- m0_lock  in  1  master 0 requests to keep ownership after the current access
- m0_rw  in  1  master 0 direction: 1 = write, 0 = read
- m0_addr  in  12  master 0 address
- m0_wdata  in  4  master 0 write data
- m0_ack  out  1  one-cycle pulse: master 0 access complete
- m0_rdata  out  4  master 0 read data; valid with m0_ack, held until next master 0 ack
- m1_req, m1_lock, m1_rw, m1_addr, m1_wdata, m1_ack, m1_rdata: same as master 0, for master 1
- mem_addr  out  12  bus address
- mem_rw  out  1  bus write strobe
- mem_wdata  out  4  bus write data
- mem_rdata  in  4  bus read data
- owner  out  1  index of the current or most recent grantee
- busy  out  1  high while an access is in flight

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: all outputs 0, FSM in IDLE, hold counter 0, last-owner 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Any req: select a winner. On the next edge, register the winner's addr/rw/wdata onto the mem_* outputs, set owner, go to ACCESS, clear the latency counter.
- ACCESS:
  - busy = 1. mem_addr, mem_rw and mem_wdata are held stable.
  - Lasts MEM_LAT cycles.
  - On the last cycle, capture mem_rdata into the owner's rdata register (also done for writes; value is don't-care), then go to DONE.
- DONE:
  - Owner's ack = 1 for exactly this cycle. mem_rw = 0. busy = 0.
  - Next state:
    - Owner's req and lock both high, and not forced-release: new access for the same owner without re-arbitration. Register new fields, go to ACCESS, hold counter +1.
    - Otherwise: hold counter cleared; go to IDLE, or go directly to ACCESS for the other master if it is requesting (same registration as IDLE).
- Forced release: hold counter == MAX_HOLD and the other master's req is high. Lock is ignored; ownership passes to the other master.
- Latency: req rising in IDLE at cycle 0 -> mem_addr valid cycle 1 -> ack cycle MEM_LAT+1. With MEM_LAT=1, ack in cycle 2.
- Back-to-back locked throughput: one access per MEM_LAT+1 cycles.
- Idle bus: mem_addr and mem_wdata hold their last values; mem_rw = 0 outside ACCESS.
- Masters:
  - Must keep fields stable from req until ack.
  - Lock is sampled only in DONE.
  - Lock with req low releases the bus.
- req dropped mid-access (protocol violation): access completes and ack still pulses.
- Non-owner's ack is always 0. Acks are never simultaneous.
- rst mid-access: access aborted, no ack; mem_rw = 0 from the cycle after rst is sampled; all state as at reset.
- Hold counter: 4 bits, saturates at MAX_HOLD, counts only same-owner locked continuations.

Optional Feature:
- Macro: BUS_ARB_RR_EN.
- Defined: round-robin. On a simultaneous request, the winner is the master that is not last-owner. last-owner updates each time a new grant is registered.
- Undefined: fixed priority. Master 0 wins every simultaneous request; last-owner is not implemented. Forced release still applies in both modes.

Test Plan:
- MEM_LAT=1. m0 read addr 0x123, mem_rdata=0xA in cycle 1 -> mem_addr=0x123 in cycle 1, m0_ack in cycle 2, m0_rdata=0xA, mem_rw=0 throughout.
- m1 write addr 0xFFF, wdata 0x5 -> mem_rw=1 for exactly MEM_LAT cycles with mem_addr=0xFFF, mem_wdata=0x5; m1_ack follows; m0_ack stays 0.
- m0 and m1 request in the same IDLE cycle, both unlocked:
  - Fixed priority: m0 acked first, m1 granted straight from DONE, then m1 acked.
  - BUS_ARB_RR_EN with last-owner=0: m1 acked first.
- m0 req+lock for 3 fetches at 0x000..0x002 while m1 requests -> three consecutive m0 acks, no m1 access interleaved, then m1 served.
- MAX_HOLD=2, m0 lock held indefinitely, m1 requesting -> after the 1st access plus 2 locked continuations, m1 granted; m0 re-served afterwards.
- rst pulsed during ACCESS -> no ack, mem_rw=0 next cycle, all outputs 0; a fresh m0 request then completes normally.
